// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
//
// A single request runs for WIDTH radix-2 steps plus a commit cycle. MULT/MULTU
// use shift-add on a 2*WIDTH accumulator. DIV/DIVU use restoring shift-subtract,
// with the remainder in the upper half and the quotient in the lower half. Signed
// operations run on magnitudes, and the sign is fixed up when the result is
// committed to HI/LO.
//
// Ports:
//   Clock      system clock, rising edge
//   Reset      synchronous, active-high; aborts any operation in flight
//   Start      request a new operation, sampled only when idle
//   Op         00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   OperandA   multiplicand / dividend
//   OperandB   multiplier / divisor
//   WriteHi    MTHI: load HI from WriteData (ignored while busy)
//   WriteLo    MTLO: load LO from WriteData (ignored while busy)
//   WriteData  data for MTHI/MTLO
//   Busy       operation in progress, from E0 up to the commit edge
//   Done       one-cycle pulse after a result is committed
//   DivByZero  one-cycle pulse with Done for a divide by zero; HI/LO are kept
//   Hi, Lo     HI/LO registers, driven straight from the flops
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic             WriteHi,
  input  logic             WriteLo,
  input  logic [WIDTH-1:0] WriteData,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StCommit
  } state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  // Multiplicand for multiply, divisor for divide (both as magnitudes).
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_q_q, neg_q_d;   // quotient/product sign
  logic                 neg_r_q, neg_r_d;   // remainder sign
  logic                 dbz_q, dbz_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 dbz_pulse_q, dbz_pulse_d;

  // Operand magnitudes; only the signed ops take absolute values.
  logic             is_signed;
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] abs_a, abs_b;

  always_comb begin
    is_signed = ~Op[0];
    sign_a    = is_signed & OperandA[WIDTH-1];
    sign_b    = is_signed & OperandB[WIDTH-1];
    abs_a     = sign_a ? (~OperandA + 1'b1) : OperandA;
    abs_b     = sign_b ? (~OperandB + 1'b1) : OperandB;
  end

  // One multiply step: add the multiplicand into the upper half when the current
  // multiplier bit is set, then shift right, keeping the carry.
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_step;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_step = {mul_sum, acc_q[WIDTH-1:1]};
  end

  // One restoring divide step. The partial remainder is WIDTH+1 bits wide after
  // the shift. A successful subtract leaves a value below the divisor, so the
  // low WIDTH bits of the difference hold it exactly.
  logic [WIDTH:0]       div_partial;
  logic [WIDTH-1:0]     div_trial;
  logic [2*WIDTH-1:0]   div_step;

  always_comb begin
    div_partial = acc_q[2*WIDTH-1:WIDTH-1];
    div_trial   = div_partial[WIDTH-1:0] - opb_q;
    if (div_partial >= {1'b0, opb_q}) begin
      div_step = {div_trial, acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_step = {acc_q[2*WIDTH-2:0], 1'b0};
    end
  end

  // Sign correction at commit.
  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quot_fixed;
  logic [WIDTH-1:0]   rem_fixed;

  always_comb begin
    prod_fixed = neg_q_q ? (~acc_q + 1'b1) : acc_q;
    quot_fixed = neg_q_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    rem_fixed  = neg_r_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    opb_d       = opb_q;
    is_div_d    = is_div_q;
    neg_q_d     = neg_q_q;
    neg_r_d     = neg_r_q;
    dbz_d       = dbz_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    done_d      = 1'b0;
    dbz_pulse_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (WriteHi) hi_d = WriteData;
        if (WriteLo) lo_d = WriteData;
        if (Start) begin
          is_div_d = Op[1];
          neg_q_d  = sign_a ^ sign_b;
          neg_r_d  = sign_a;
          dbz_d    = Op[1] & (OperandB == '0);
          cnt_d    = '0;
          if (Op[1]) begin
            opb_d = abs_b;
            acc_d = {{WIDTH{1'b0}}, abs_a};
          end else begin
            opb_d = abs_a;
            acc_d = {{WIDTH{1'b0}}, abs_b};
          end
          state_d = StRun;
        end
      end

      StRun: begin
        acc_d = is_div_q ? div_step : mul_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StCommit;
        end
      end

      StCommit: begin
        if (!is_div_q) begin
          hi_d = prod_fixed[2*WIDTH-1:WIDTH];
          lo_d = prod_fixed[WIDTH-1:0];
        end else if (!dbz_q) begin
          hi_d = rem_fixed;
          lo_d = quot_fixed;
        end
        done_d      = 1'b1;
        dbz_pulse_d = dbz_q;
        state_d     = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      acc_q       <= '0;
      opb_q       <= '0;
      is_div_q    <= 1'b0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      dbz_q       <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      done_q      <= 1'b0;
      dbz_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      opb_q       <= opb_d;
      is_div_q    <= is_div_d;
      neg_q_q     <= neg_q_d;
      neg_r_q     <= neg_r_d;
      dbz_q       <= dbz_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      done_q      <= done_d;
      dbz_pulse_q <= dbz_pulse_d;
    end
  end

  assign Busy      = (state_q != StIdle);
  assign Done      = done_q;
  assign DivByZero = dbz_pulse_q;
  assign Hi        = hi_q;
  assign Lo        = lo_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide unit sitting downstream of the register file. It consumes the two register read operands (ReadData1/ReadData2) for MULT, MULTU, DIV and DIVU. Results go into internal HI/LO registers, which are read back by the MFHI/MFLO datapath and written directly by MTHI/MTLO. It raises Busy so the control unit stalls the PC while an operation is in flight.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count equals WIDTH.

Ports:
Clock  input  1  system clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset
Start  input  1  request a new operation; sampled only when idle
Op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
OperandA  input  WIDTH  multiplicand / dividend (from ReadData1)
OperandB  input  WIDTH  multiplier / divisor (from ReadData2)
WriteHi  input  1  MTHI: load HI from WriteData
WriteLo  input  1  MTLO: load LO from WriteData
WriteData  input  WIDTH  data for MTHI/MTLO
Busy  output  1  operation in progress; control must stall
Done  output  1  one-cycle pulse when a result is committed
DivByZero  output  1  one-cycle pulse with Done when DIV/DIVU had OperandB==0
Hi  output  WIDTH  HI register (product high half / remainder)
Lo  output  WIDTH  LO register (product low half / quotient)

Behaviour:
- Interface: one clock (Clock); reset is synchronous and active-high (Reset).
- Reset (highest priority, also mid-operation): state IDLE, Hi=0, Lo=0, Busy=0, Done=0, DivByZero=0, counter=0. Any in-flight operation is discarded.
- FSM states: IDLE -> RUN -> COMMIT -> IDLE.
- IDLE: on a rising edge with Start=1 (edge E0), latch Op. Latch |OperandA| and |OperandB|, using absolute values only for signed ops. Record the result sign (quotient/product sign = signA XOR signB; remainder sign = signA). Clear the counter and go to RUN.
- RUN: one radix-2 step per edge, on edges E1..E32 (WIDTH edges). Multiply uses shift-add on a 2*WIDTH accumulator. Divide uses restoring shift-subtract, with the remainder in the upper half and the quotient in the lower half. After WIDTH steps, go to COMMIT.
- COMMIT (edge E33 = E0+WIDTH+1): apply the two's-complement sign correction and write Hi/Lo. Assert Done=1 for the cycle following E33, then return to IDLE.
- Busy=1 for the cycles between E0 and E33 (WIDTH+1 cycles). Busy=0 in the cycle Done is high, so a new Start is accepted on that same cycle's edge.
- Done and DivByZero are registered pulses, exactly one cycle wide.
- Signed division truncates toward zero; the remainder takes the dividend's sign.
- Overflow case 0x80000000 / 0xFFFFFFFF (DIV): Lo=0x80000000, Hi=0x00000000. No flag.
- Divide by zero: same latency as a normal divide. Hi and Lo are left unchanged, and DivByZero=1 together with Done.
- Start while Busy=1: ignored, no queuing. Operand changes after E0 have no effect.
- WriteHi/WriteLo while Busy=1: ignored. While idle: the register loads WriteData on the next edge.
- Start together with WriteHi/WriteLo while idle: both are accepted. The MTHI/MTLO value is visible until COMMIT overwrites it.
- WriteHi and WriteLo both set: both registers load WriteData.
- Hi/Lo outputs come straight from the registers, with no combinational path from the operands.

Test Plan:
- Reset, then MULT A=0xFFFFFFFF, B=0x00000005 -> Busy high for 33 cycles, Done pulse once, Hi=0xFFFFFFFF, Lo=0xFFFFFFFB.
- MULTU A=0xFFFFFFFF, B=0x00000005 -> Hi=0x00000004, Lo=0xFFFFFFFB. Then DIVU A=100, B=7 -> Lo=0x0000000E, Hi=0x00000002.
- DIV A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. Then DIV A=0x80000000, B=0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- WriteHi=1 with WriteData=0x12345678, WriteLo=1 with WriteData=0x9ABCDEF0 while idle; then DIVU B=0 -> DivByZero and Done pulse together, Hi=0x12345678, Lo=0x9ABCDEF0 unchanged.
- Start a MULT, then assert Start with different operands and WriteHi at cycle 10 -> both ignored, and the result matches the first operands. Back-to-back Start on the Done cycle is accepted.
- Start DIV, assert Reset at cycle 15 -> next cycle Busy=0, Hi=Lo=0, and no Done pulse ever appears for the aborted op.
